// File: rtl/freq_equa_pkg.sv
// Shared constants, swap-FSM state type and datapath width helpers for the frequency-equaliser multiplier.
// The optional saturation counter is enabled by FREQ_EQUA_SATCNT_EN (see freq_equa_cmult.sv).
package freq_equa_pkg;

   localparam int unsigned LAT        = 3;
   localparam int unsigned MAX_LANES  = 8;
   localparam int unsigned LANE_SEL_W = $clog2(MAX_LANES);

   typedef enum logic {
      SWAP_IDLE    = 1'b0,
      SWAP_PENDING = 1'b1
   } swap_state_e;

   function automatic int unsigned prod_w(input int unsigned data_w, input int unsigned coef_w);
      return data_w + coef_w;
   endfunction

   // One headroom bit above the product so the rounding offset can never wrap.
   function automatic int unsigned rnd_w(input int unsigned data_w, input int unsigned coef_w);
      return data_w + coef_w + 1;
   endfunction

endpackage

// File: rtl/freq_equa_cmult_if.sv
// Stream, coefficient-write and bank-swap signals of freq_equa_cmult bundled as one interface.
// master = upstream driver / coefficient host, slave = the multiplier.
interface freq_equa_cmult_if
   import freq_equa_pkg::*;
#(
   parameter int unsigned DATA_W    = 23,
   parameter int unsigned COEF_W    = 16,
   parameter int unsigned NUM_LANES = 4,
   parameter int unsigned CNT_W     = 9
);

   logic                          en_sync_in;
   logic [CNT_W-1:0]              cnt_sync_in;
   logic [NUM_LANES*DATA_W-1:0]   re_in;
   logic [NUM_LANES*DATA_W-1:0]   im_in;
   logic                          coef_we;
   logic [LANE_SEL_W-1:0]         coef_lane;
   logic [CNT_W-1:0]              coef_addr;
   logic signed [COEF_W-1:0]      coef_wdata;
   logic                          swap_req;
   logic                          swap_ack;
   logic                          active_bank;
   logic                          en_sync_out;
   logic [CNT_W-1:0]              cnt_sync_out;
   logic [NUM_LANES*DATA_W-1:0]   re_out;
   logic [NUM_LANES*DATA_W-1:0]   im_out;
   logic                          sat_flag;

   modport master (
      output en_sync_in, cnt_sync_in, re_in, im_in,
      output coef_we, coef_lane, coef_addr, coef_wdata, swap_req,
      input  swap_ack, active_bank, en_sync_out, cnt_sync_out, re_out, im_out, sat_flag
   );

   modport slave (
      input  en_sync_in, cnt_sync_in, re_in, im_in,
      input  coef_we, coef_lane, coef_addr, coef_wdata, swap_req,
      output swap_ack, active_bank, en_sync_out, cnt_sync_out, re_out, im_out, sat_flag
   );

endinterface

// File: rtl/freq_equa_lane.sv
// One equaliser lane: dual-bank coefficient RAM, re/im multipliers and round/saturate stage.
// Three register stages: coefficient+data, products, rounded outputs.
module freq_equa_lane
   import freq_equa_pkg::*;
#(
   parameter int unsigned DATA_W = 23,
   parameter int unsigned COEF_W = 16,
   parameter int unsigned FRAC_W = 14,
   parameter int unsigned CNT_W  = 9
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic                     wr_bank,
   input  logic [CNT_W-1:0]         wr_addr,
   input  logic signed [COEF_W-1:0] wr_data,
   input  logic                     rd_bank,
   input  logic [CNT_W-1:0]         rd_addr,
   input  logic signed [DATA_W-1:0] re_in,
   input  logic signed [DATA_W-1:0] im_in,
   output logic signed [DATA_W-1:0] re_out,
   output logic signed [DATA_W-1:0] im_out,
   output logic                     sat_out
);

   localparam int unsigned PW    = prod_w(DATA_W, COEF_W);
   localparam int unsigned RW    = rnd_w(DATA_W, COEF_W);
   localparam int unsigned DEPTH = 2 ** (CNT_W + 1);

   localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(2 ** FRAC_W);
   localparam logic signed [RW-1:0]     HALF  = RW'(2 ** (FRAC_W - 1));
   localparam logic signed [RW-1:0]     MAXV  = RW'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [RW-1:0]     MINV  = -RW'(2 ** (DATA_W - 1));

   // Both banks power up holding unity gain; address = {bank, bin}.
   logic signed [COEF_W-1:0] mem [DEPTH] = '{default: UNITY};

   function automatic logic signed [RW-1:0] round_p(input logic signed [PW-1:0] p);
      logic signed [RW-1:0] t;
      t = RW'(p) + HALF;
      return t >>> FRAC_W;
   endfunction

   function automatic logic sat_hit(input logic signed [RW-1:0] y);
      return (y > MAXV) || (y < MINV);
   endfunction

   function automatic logic signed [DATA_W-1:0] sat_p(input logic signed [RW-1:0] y);
      if (y > MAXV) return DATA_W'(MAXV);
      if (y < MINV) return DATA_W'(MINV);
      return DATA_W'(y);
   endfunction

   logic signed [DATA_W-1:0] re_p1_q, re_p1_d, im_p1_q, im_p1_d;
   logic signed [COEF_W-1:0] coef_p1_q, coef_p1_d;
   logic signed [PW-1:0]     prod_re_p2_q, prod_re_p2_d, prod_im_p2_q, prod_im_p2_d;
   logic signed [DATA_W-1:0] re_p3_q, re_p3_d, im_p3_q, im_p3_d;
   logic                     sat_p3_q, sat_p3_d;
   logic signed [RW-1:0]     rnd_re, rnd_im;

   always_ff @(posedge clk) begin
      if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
   end

   always_comb begin
      // stage 1: coefficient lookup, input capture
      coef_p1_d    = mem[{rd_bank, rd_addr}];
      re_p1_d      = re_in;
      im_p1_d      = im_in;
      // stage 2: full-precision products
      prod_re_p2_d = PW'(re_p1_q) * PW'(coef_p1_q);
      prod_im_p2_d = PW'(im_p1_q) * PW'(coef_p1_q);
      // stage 3: round half up, clamp
      rnd_re       = round_p(prod_re_p2_q);
      rnd_im       = round_p(prod_im_p2_q);
      re_p3_d      = sat_p(rnd_re);
      im_p3_d      = sat_p(rnd_im);
      sat_p3_d     = sat_hit(rnd_re) || sat_hit(rnd_im);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         re_p1_q      <= '0;
         im_p1_q      <= '0;
         coef_p1_q    <= '0;
         prod_re_p2_q <= '0;
         prod_im_p2_q <= '0;
         re_p3_q      <= '0;
         im_p3_q      <= '0;
         sat_p3_q     <= 1'b0;
      end else begin
         re_p1_q      <= re_p1_d;
         im_p1_q      <= im_p1_d;
         coef_p1_q    <= coef_p1_d;
         prod_re_p2_q <= prod_re_p2_d;
         prod_im_p2_q <= prod_im_p2_d;
         re_p3_q      <= re_p3_d;
         im_p3_q      <= im_p3_d;
         sat_p3_q     <= sat_p3_d;
      end
   end

   assign re_out  = re_p3_q;
   assign im_out  = im_p3_q;
   assign sat_out = sat_p3_q;

endmodule

// File: rtl/freq_equa_cmult.sv
// Multi-lane frequency-equaliser multiplier: NUM_LANES lanes, bank-swap FSM and en/cnt delay line.
// Define FREQ_EQUA_SATCNT_EN to add the sat_cnt_clr input and 16-bit saturation counter sat_cnt.
module freq_equa_cmult
   import freq_equa_pkg::*;
#(
   parameter int unsigned DATA_W    = 23,
   parameter int unsigned COEF_W    = 16,
   parameter int unsigned FRAC_W    = 14,
   parameter int unsigned NUM_LANES = 4,
   parameter int unsigned CNT_W     = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   freq_equa_cmult_if.slave  bus
`ifdef FREQ_EQUA_SATCNT_EN
   ,
   input  logic              sat_cnt_clr,
   output logic [15:0]       sat_cnt
`endif
);

   swap_state_e state_q, state_d;
   logic        active_bank_q, active_bank_d;
   logic        swap_ack_q, swap_ack_d;
   logic        frame_start;

   logic [LAT-1:0]            en_dly_q, en_dly_d;
   logic [LAT-1:0][CNT_W-1:0] cnt_dly_q, cnt_dly_d;

   logic [DATA_W-1:0]           re_lane [NUM_LANES];
   logic [DATA_W-1:0]           im_lane [NUM_LANES];
   logic [NUM_LANES-1:0]        sat_lane;
   logic [NUM_LANES*DATA_W-1:0] re_all, im_all;

   assign frame_start = bus.en_sync_in && (bus.cnt_sync_in == '0);

   always_comb begin
      state_d       = state_q;
      active_bank_d = active_bank_q;
      swap_ack_d    = 1'b0;
      case (state_q)
         SWAP_IDLE: begin
            if (bus.swap_req) state_d = SWAP_PENDING;
         end
         SWAP_PENDING: begin
            if (frame_start) begin
               state_d       = SWAP_IDLE;
               active_bank_d = ~active_bank_q;
               swap_ack_d    = 1'b1;
            end
         end
         default: state_d = SWAP_IDLE;
      endcase
      en_dly_d  = {en_dly_q[LAT-2:0], bus.en_sync_in};
      cnt_dly_d = {cnt_dly_q[LAT-2:0], bus.cnt_sync_in};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= SWAP_IDLE;
         active_bank_q <= 1'b0;
         swap_ack_q    <= 1'b0;
         en_dly_q      <= '0;
         cnt_dly_q     <= '0;
      end else begin
         state_q       <= state_d;
         active_bank_q <= active_bank_d;
         swap_ack_q    <= swap_ack_d;
         en_dly_q      <= en_dly_d;
         cnt_dly_q     <= cnt_dly_d;
      end
   end

   // Reads follow active_bank_d so the frame-start sample already sees the new bank;
   // writes target the pre-swap shadow, which is the bank becoming active.
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      freq_equa_lane #(
         .DATA_W (DATA_W),
         .COEF_W (COEF_W),
         .FRAC_W (FRAC_W),
         .CNT_W  (CNT_W)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (bus.coef_we && (bus.coef_lane == LANE_SEL_W'(g))),
         .wr_bank (~active_bank_q),
         .wr_addr (bus.coef_addr),
         .wr_data (bus.coef_wdata),
         .rd_bank (active_bank_d),
         .rd_addr (bus.cnt_sync_in),
         .re_in   (bus.re_in[g*DATA_W +: DATA_W]),
         .im_in   (bus.im_in[g*DATA_W +: DATA_W]),
         .re_out  (re_lane[g]),
         .im_out  (im_lane[g]),
         .sat_out (sat_lane[g])
      );
   end

   always_comb begin
      re_all = '0;
      im_all = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         re_all[l*DATA_W +: DATA_W] = re_lane[l];
         im_all[l*DATA_W +: DATA_W] = im_lane[l];
      end
   end

   assign bus.re_out       = re_all;
   assign bus.im_out       = im_all;
   assign bus.sat_flag     = |sat_lane;
   assign bus.en_sync_out  = en_dly_q[LAT-1];
   assign bus.cnt_sync_out = cnt_dly_q[LAT-1];
   assign bus.swap_ack     = swap_ack_q;
   assign bus.active_bank  = active_bank_q;

`ifdef FREQ_EQUA_SATCNT_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;

   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (sat_cnt_clr) sat_cnt_d = '0;
      else if (bus.en_sync_out && bus.sat_flag && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) sat_cnt_q <= '0;
      else        sat_cnt_q <= sat_cnt_d;
   end

   assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: doc/freq_equa_cmult.md
Name: freq_equa_cmult

Overview:
- Parametrised successor of the single-lane frequency-equaliser multiplier.
- Scales NUM_LANES complex FFT bins (re/im) by a real per-bin coefficient.
- Per-bin coefficients come from internal double-buffered coefficient RAMs, indexed by the bin counter.
- Performs rounding and saturation; pipelines en/cnt sync alongside the data. Sits between the FFT output and the detection/accumulation stage.

Parameters:
- DATA_W, 23, signed re/im width, in and out
- COEF_W, 16, signed coefficient width
- FRAC_W, 14, fractional bits of coefficient; unity = 2^FRAC_W
- NUM_LANES, 4, parallel complex lanes, 1..8
- CNT_W, 9, bin counter width; RAM depth per bank = 2^CNT_W

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en_sync_in  in  1  input sample valid
- cnt_sync_in  in  CNT_W  bin index of current input
- re_in  in  NUM_LANES*DATA_W  packed signed real parts, lane 0 in LSBs
- im_in  in  NUM_LANES*DATA_W  packed signed imag parts
- coef_we  in  1  coefficient write strobe
- coef_lane  in  3  target lane for write
- coef_addr  in  CNT_W  target bin for write
- coef_wdata  in  COEF_W  signed coefficient
- swap_req  in  1  pulse: request shadow/active bank swap
- swap_ack  out  1  one-cycle pulse when swap applied
- active_bank  out  1  current read bank
- en_sync_out  out  1  output valid
- cnt_sync_out  out  CNT_W  bin index aligned to outputs
- re_out  out  NUM_LANES*DATA_W  scaled real
- im_out  out  NUM_LANES*DATA_W  scaled imag
- sat_flag  out  1  any lane/component saturated this output cycle

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0; active_bank=0; swap pending cleared; pipeline regs 0. RAM contents unchanged.
- RAM power-up init: every entry = 2^FRAC_W (unity) in both banks.
- Latency is fixed at 3 cycles, regardless of en:
  - T+1: coefficient read from active bank at cnt_sync_in; data registered.
  - T+2: full-precision products re*coef, im*coef registered (DATA_W+COEF_W signed).
  - T+3: round, shift and saturate; outputs registered.
- en_sync_out and cnt_sync_out are en_sync_in and cnt_sync_in delayed exactly 3 cycles. Data pipeline runs every cycle.
- Arithmetic:
  - y = (p + 2^(FRAC_W-1)) >>> FRAC_W, arithmetic shift (round half up).
  - Clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - sat_flag = OR of all clamp events, aligned with outputs.
- Writes: when coef_we=1, write coef_wdata to the shadow bank (~active_bank) at [coef_lane][coef_addr]. coef_lane >= NUM_LANES is ignored. The active bank is never written.
- Swap FSM:
  - States IDLE, PENDING.
  - IDLE: swap_req moves to PENDING.
  - PENDING: at the first cycle with en_sync_in=1 and cnt_sync_in=0 (frame start), toggle active_bank, pulse swap_ack, and return to IDLE. The frame-start sample itself reads the new bank.
  - swap_req while PENDING is absorbed (no double swap).
  - swap_req and frame start in the same cycle in IDLE: go to PENDING only; swap happens at the next frame start.
- Write in the same cycle as a swap: the write lands in the pre-swap shadow bank, which becomes active.
- Reset mid-frame or mid-pending: pending request dropped; active_bank returns to 0; RAM kept.
- cnt wrap 2^CNT_W-1 -> 0 is the frame boundary; no other frame marker.

Optional Feature:
- Macro: FREQ_EQUA_SATCNT_EN.
- With the macro:
  - Adds input sat_cnt_clr (1 bit) and output sat_cnt (16 bits).
  - sat_cnt increments by 1 on each cycle where en_sync_out=1 and sat_flag=1, and saturates at 0xFFFF.
  - Synchronous clear by sat_cnt_clr (clear wins over increment). Reset value 0.
- Without the macro: neither port exists; no counter logic.

Decomposition:
- Shared package freq_equa_pkg:
  - Constants: LAT=3, MAX_LANES=8.
  - Swap FSM state typedef.
  - Round/saturate width functions.
- Sub-module freq_equa_lane: one lane's coefficient dual-bank RAM, two multipliers and round/saturate stage. The top instantiates NUM_LANES copies plus the swap FSM and the sync delay line.

Test Plan:
- Reset, then unity coefficients; re_in=1000, im_in=-1000 on all lanes, en=1, cnt=5 -> 3 cycles later re_out=1000, im_out=-1000, cnt_sync_out=5, sat_flag=0.
- Write lane 2 bin 7 coef=8192 (0.5) plus swap_req, then drive a frame: cnt 0..511 -> swap_ack at cnt=0. Lane 2 bin 7 with re=3 gives 2 (1.5 rounds up); im=-3 gives -1; other lanes unchanged.
- Coefficient 32767 at bin 0, re_in=4194303 -> re_out=4194303, sat_flag=1; re_in=-4194304 -> re_out=-4194304, sat_flag=1.
- swap_req twice in PENDING, then frame start -> exactly one swap_ack and active_bank toggles once. swap_req at cnt=0 -> swap only at the next cnt=0.
- rst_n=0 while PENDING at cnt=200 -> outputs 0, active_bank=0, no swap_ack at the following frame start. RAM values written earlier are still readable after a later swap.
- With FREQ_EQUA_SATCNT_EN: 5 saturating valid samples -> sat_cnt=5. sat_cnt_clr in the same cycle as a saturation event -> sat_cnt=0.
